// File: rtl/mux_scan_controller_pkg.sv
// Shared definitions for the mux scan controller: FSM state encoding and
// dwell counter sizing.
`timescale 1ns/1ps
package mux_scan_controller_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam int DWELL_MAX = 255;
  localparam int DWELL_CW  = 8;

endpackage

// File: rtl/mux_four_one.sv
// Combinational 4:1 mux in sum-of-products form; scanned by the controller.
`timescale 1ns/1ps
module mux_four_one (
  input  logic w0,
  input  logic w1,
  input  logic w2,
  input  logic w3,
  input  logic s0,
  input  logic s1,
  output logic y
);

  assign y = (w0 & ~s1 & ~s0) |
             (w1 & ~s1 &  s0) |
             (w2 &  s1 & ~s0) |
             (w3 &  s1 &  s0);

endmodule

// File: rtl/mux_scan_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the terminal
// count so the controller knows when y has settled and may be sampled.
`timescale 1ns/1ps
module mux_scan_dwell_counter
  import mux_scan_controller_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [DWELL_CW-1:0] TC_VAL = DWELL_CW'(DWELL - 1);

  logic [DWELL_CW-1:0] cnt_reg;

  assign tc = (cnt_reg == TC_VAL);

  // Clear has priority so an abort always restarts the dwell from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tc ? '0 : cnt_reg + DWELL_CW'(1);
    end
  end

endmodule

// File: rtl/mux_scan_controller.sv
// Steps the select lines of an external N:1 mux, samples y after each dwell
// period and publishes the assembled word with a one-cycle valid pulse.
`timescale 1ns/1ps
module mux_scan_controller
  import mux_scan_controller_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    y,
  output logic [SEL_W-1:0]        sel,
  output logic                    busy,
  output logic [(2**SEL_W)-1:0]   data_out,
  output logic                    valid
);

  localparam int N = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [N-1:0]     shadow_reg, shadow_next;
  logic [N-1:0]     data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             cnt_clr;
  logic             cnt_en;
  logic             dwell_tc;

  mux_scan_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (dwell_tc)
  );

  assign cnt_en = (state_reg == ST_SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= '0;
      shadow_reg <= '0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      shadow_reg <= shadow_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    shadow_next = shadow_reg;
    data_next   = data_reg;
    valid_next  = 1'b0;
    cnt_clr     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        sel_next = '0;
        cnt_clr  = 1'b1;
        if (start && !abort) begin
          state_next  = ST_SCAN;
          shadow_next = '0;
        end
      end
      ST_SCAN: begin
        // Abort beats a coinciding final sample: no capture, no pulse.
        if (abort) begin
          state_next = ST_IDLE;
          sel_next   = '0;
          cnt_clr    = 1'b1;
        end else if (dwell_tc) begin
          shadow_next[sel_reg] = y;
          if (sel_reg == SEL_LAST) begin
            data_next  = {y, shadow_reg[N-2:0]};
            valid_next = 1'b1;
            sel_next   = '0;
            state_next = ST_IDLE;
          end else begin
            sel_next = sel_reg + SEL_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        sel_next   = '0;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  assign sel      = sel_reg;
  assign busy     = (state_reg == ST_SCAN);
  assign data_out = data_reg;
  assign valid    = valid_reg;

endmodule
